// File: rtl/timer_arbiter.sv
// Fixed-priority arbiter and sequencer for the shared alarm countdown.
// Grants one requester, loads its interval value, counts down on 1 Hz ticks, then pulses done.
module timer_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            one_hz_enable,
  input  logic [NREQ-1:0] req,
  input  logic [CW-1:0]   value,
  output logic [1:0]      interval,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic [CW-1:0]   remaining
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] TOP = 2'(NREQ - 1);

  state_t          state, state_d;
  logic [1:0]      g, g_d;
  logic [1:0]      interval_d;
  logic [NREQ-1:0] grant_d, done_d, served, served_d;
  logic [CW-1:0]   remaining_d;
  logic            busy_d;

  logic [NREQ-1:0] elig;
  logic [1:0]      win;
  logic            any_elig;
  logic            active, preempt, cancel;

  assign elig     = req & ~served;
  assign any_elig = |elig;
  assign active   = (state == S_LOAD) || (state == S_COUNT);
  assign preempt  = active && (g != TOP) && elig[NREQ-1];
  assign cancel   = active && !req[g];

  // Ascending scan so the highest eligible index wins.
  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (elig[i]) win = 2'(i);
    end
  end

  always_comb begin
    state_d     = state;
    g_d         = g;
    grant_d     = grant;
    done_d      = '0;
    interval_d  = interval;
    remaining_d = remaining;
    served_d    = served & req;

    case (state)
      S_IDLE: begin
        if (any_elig) begin
          g_d        = win;
          grant_d    = NREQ'(1) << win;
          interval_d = win;
          state_d    = S_LOAD;
        end
      end

      S_LOAD, S_COUNT: begin
        // Preemption outranks cancel: both land in a fresh LOAD for the top requester.
        if (preempt) begin
          g_d        = TOP;
          grant_d    = NREQ'(1) << TOP;
          interval_d = TOP;
          state_d    = S_LOAD;
        end else if (cancel) begin
          grant_d = '0;
          state_d = S_IDLE;
        end else if (state == S_LOAD) begin
          if (value == '0) begin
            remaining_d = '0;
            done_d      = grant;
            state_d     = S_DONE;
          end else begin
            remaining_d = value;
            state_d     = S_COUNT;
          end
        end else if (one_hz_enable) begin
          if (remaining == CW'(1)) begin
            remaining_d = '0;
            done_d      = grant;
            state_d     = S_DONE;
          end else begin
            remaining_d = remaining - CW'(1);
          end
        end
      end

      S_DONE: begin
        grant_d  = '0;
        served_d = (served | grant) & req;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      g         <= '0;
      grant     <= '0;
      done      <= '0;
      interval  <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      served    <= '0;
    end else begin
      state     <= state_d;
      g         <= g_d;
      grant     <= grant_d;
      done      <= done_d;
      interval  <= interval_d;
      remaining <= remaining_d;
      busy      <= busy_d;
      served    <= served_d;
    end
  end

endmodule
